// File: rtl/cci_pkg.sv
// Shared defaults and the request record for the CCI line-memory responder.
package cci_pkg;

  localparam int CCI_ADDR_LMT    = 20;
  localparam int CCI_MDATA       = 14;
  localparam int CCI_CACHE_WIDTH = 512;
  localparam int CCI_MEM_AW      = 10;
  localparam int CCI_FIFO_AW     = 4;
  localparam int CCI_AF_SLACK    = 4;

  // One queued request. The read FIFO only carries the fields it needs,
  // so this record is the payload of the write FIFO.
  typedef struct packed {
    logic [CCI_ADDR_LMT-1:0]    addr;
    logic [CCI_MDATA-1:0]       mdata;
    logic [CCI_CACHE_WIDTH-1:0] data;
  } cci_req_t;

  // Occupancy at which almostfull asserts.
  function automatic int af_thresh(input int depth, input int slack);
    return depth - slack;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered almostfull and a drop-on-full push.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almostfull_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             af_q;
  logic             push_ok, pop_ok;

  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == CW'(DEPTH));
  // A push while full is dropped even if a pop happens on the same edge.
  assign push_ok      = push_i & ~full_o;
  assign pop_ok       = pop_i & ~empty_o;
  assign overflow_o   = push_i & full_o;
  assign dout_o       = mem_q[rd_ptr_q];
  assign almostfull_o = af_q;

  // Next occupancy from accepted push/pop.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Pointers, occupancy and almostfull, registered from next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      af_q    <= (count_d >= CW'(AF_THRESH));
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cci_mem_responder.sv
// CCI-style memory responder: queued reads/writes against an on-chip line RAM.
module cci_mem_responder
  import cci_pkg::*;
#(
  // Widths must match cci_req_t in cci_pkg; the write FIFO carries that record.
  parameter int ADDR_LMT    = CCI_ADDR_LMT,
  parameter int MDATA       = CCI_MDATA,
  parameter int CACHE_WIDTH = CCI_CACHE_WIDTH,
  parameter int MEM_AW      = CCI_MEM_AW,
  parameter int FIFO_AW     = CCI_FIFO_AW,
  parameter int AF_SLACK    = CCI_AF_SLACK
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  input  logic                   mem_stall,
  output logic                   overflow_err
);

  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam int AF_TH      = af_thresh(FIFO_DEPTH, AF_SLACK);
  localparam int RD_W       = MEM_AW + MDATA;

  // Read FIFO holds only the line index and tag; upper address bits wrap away.
  logic [RD_W-1:0]   rd_din, rd_head;
  logic              rd_empty, rd_full, rd_ovf, rd_af;
  cci_req_t          wr_din, wr_head;
  logic              wr_empty, wr_full, wr_ovf, wr_af;
  logic              rd_pop, wr_pop;
  logic              unused_bits;

  assign rd_din = {rd_req_addr[MEM_AW-1:0], rd_req_mdata};
  assign wr_din = '{addr: wr_req_addr, mdata: wr_req_mdata, data: wr_req_data};
  assign rd_pop = ~rd_empty & ~mem_stall;
  assign wr_pop = ~wr_empty & ~mem_stall;
  assign unused_bits = ^{rd_req_addr[ADDR_LMT-1:MEM_AW], wr_head.addr[ADDR_LMT-1:MEM_AW],
                         rd_full, wr_full};

  sync_fifo #(.WIDTH(RD_W), .DEPTH(FIFO_DEPTH), .AF_THRESH(AF_TH)) u_rd_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(rd_req_en), .din_i(rd_din), .pop_i(~mem_stall), .dout_o(rd_head),
    .empty_o(rd_empty), .full_o(rd_full), .almostfull_o(rd_af), .overflow_o(rd_ovf)
  );

  sync_fifo #(.WIDTH($bits(cci_req_t)), .DEPTH(FIFO_DEPTH), .AF_THRESH(AF_TH)) u_wr_fifo (
    .clk(clk), .reset_n(reset_n),
    .push_i(wr_req_en), .din_i(wr_din), .pop_i(~mem_stall), .dout_o(wr_head),
    .empty_o(wr_empty), .full_o(wr_full), .almostfull_o(wr_af), .overflow_o(wr_ovf)
  );

  logic [CACHE_WIDTH-1:0] mem [1 << MEM_AW];
  logic [CACHE_WIDTH-1:0] ram_rd_q;

  logic                   rd_s1_valid_q, rd_s2_valid_q;
  logic [MEM_AW-1:0]      rd_s1_addr_q;
  logic [MDATA-1:0]       rd_s1_mdata_q, rd_s2_mdata_q;
  logic                   wr_s1_valid_q, wr_s1_odd_q;
  logic [MDATA-1:0]       wr_s1_mdata_q;

  logic                   rd_rsp_valid_q, wr_rsp0_valid_q, wr_rsp1_valid_q, overflow_q;
  logic [MDATA-1:0]       rd_rsp_mdata_q, wr_rsp0_mdata_q, wr_rsp1_mdata_q;
  logic [CACHE_WIDTH-1:0] rd_rsp_data_q;

  // RAM write port: the write is committed on the same edge it leaves its FIFO.
  // A read popped on that edge reads the RAM one edge later, so it sees the new line.
  always_ff @(posedge clk) begin
    if (wr_pop) mem[wr_head.addr[MEM_AW-1:0]] <= wr_head.data;
  end

  // RAM read port, registered, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    ram_rd_q <= mem[rd_s1_addr_q];
  end

  // Pipeline stages and response registers; idle outputs are held at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_s1_valid_q   <= 1'b0;
      rd_s1_addr_q    <= '0;
      rd_s1_mdata_q   <= '0;
      rd_s2_valid_q   <= 1'b0;
      rd_s2_mdata_q   <= '0;
      wr_s1_valid_q   <= 1'b0;
      wr_s1_odd_q     <= 1'b0;
      wr_s1_mdata_q   <= '0;
      rd_rsp_valid_q  <= 1'b0;
      rd_rsp_mdata_q  <= '0;
      rd_rsp_data_q   <= '0;
      wr_rsp0_valid_q <= 1'b0;
      wr_rsp0_mdata_q <= '0;
      wr_rsp1_valid_q <= 1'b0;
      wr_rsp1_mdata_q <= '0;
      overflow_q      <= 1'b0;
    end else begin
      rd_s1_valid_q   <= rd_pop;
      rd_s1_addr_q    <= rd_head[RD_W-1:MDATA];
      rd_s1_mdata_q   <= rd_head[MDATA-1:0];
      rd_s2_valid_q   <= rd_s1_valid_q;
      rd_s2_mdata_q   <= rd_s1_mdata_q;
      wr_s1_valid_q   <= wr_pop;
      wr_s1_odd_q     <= wr_head.addr[0];
      wr_s1_mdata_q   <= wr_head.mdata;
      rd_rsp_valid_q  <= rd_s2_valid_q;
      rd_rsp_mdata_q  <= rd_s2_valid_q ? rd_s2_mdata_q : '0;
      rd_rsp_data_q   <= rd_s2_valid_q ? ram_rd_q : '0;
      wr_rsp0_valid_q <= wr_s1_valid_q & ~wr_s1_odd_q;
      wr_rsp0_mdata_q <= (wr_s1_valid_q & ~wr_s1_odd_q) ? wr_s1_mdata_q : '0;
      wr_rsp1_valid_q <= wr_s1_valid_q & wr_s1_odd_q;
      wr_rsp1_mdata_q <= (wr_s1_valid_q & wr_s1_odd_q) ? wr_s1_mdata_q : '0;
      overflow_q      <= overflow_q | rd_ovf | wr_ovf;
    end
  end

  assign rd_req_almostfull = rd_af;
  assign wr_req_almostfull = wr_af;
  assign rd_rsp_valid      = rd_rsp_valid_q;
  assign rd_rsp_mdata      = rd_rsp_mdata_q;
  assign rd_rsp_data       = rd_rsp_data_q;
  assign wr_rsp0_valid     = wr_rsp0_valid_q;
  assign wr_rsp0_mdata     = wr_rsp0_mdata_q;
  assign wr_rsp1_valid     = wr_rsp1_valid_q;
  assign wr_rsp1_mdata     = wr_rsp1_mdata_q;
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_cci_mem_responder.sv
// Directed bench for cci_mem_responder with hand-computed expectations.
module tb_cci_mem_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [19:0]  rd_req_addr, wr_req_addr;
  logic [13:0]  rd_req_mdata, wr_req_mdata;
  logic [511:0] wr_req_data;
  logic         rd_req_en, wr_req_en, mem_stall;
  logic         rd_req_almostfull, wr_req_almostfull;
  logic         rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid, overflow_err;
  logic [13:0]  rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [511:0] rd_rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cci_mem_responder dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .mem_stall(mem_stall), .overflow_err(overflow_err)
  );

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rd_req_en = 0; wr_req_en = 0; mem_stall = 0;
    rd_req_addr = '0; rd_req_mdata = '0; wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
    tick(); tick();
    n_cmp++; if ({rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid} !== 3'b000) begin
      n_bad++; $display("FAIL reset_valids: got %b want 000", {rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid}); end
    n_cmp++; if ({rd_req_almostfull, wr_req_almostfull, overflow_err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {rd_req_almostfull, wr_req_almostfull, overflow_err}); end
    n_cmp++; if ({rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata} !== 42'h0) begin
      n_bad++; $display("FAIL reset_mdata: got %h want 0", {rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata}); end
    n_cmp++; if (rd_rsp_data !== 512'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", rd_rsp_data); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr_req_en = 1; wr_req_addr = 20'h5; wr_req_mdata = 14'h11; wr_req_data = {64{8'hA5}};
    tick();                                   // N
    wr_req_en = 0; rd_req_en = 1; rd_req_addr = 20'h5; rd_req_mdata = 14'h22;
    tick();                                   // N+1
    rd_req_en = 0;
    tick();                                   // N+2
    n_cmp++; if (wr_rsp1_valid !== 1'b1 || wr_rsp1_mdata !== 14'h11) begin
      n_bad++; $display("FAIL wr_rsp1_n2: got v=%b m=%h want v=1 m=11", wr_rsp1_valid, wr_rsp1_mdata); end
    n_cmp++; if (wr_rsp0_valid !== 1'b0 || wr_rsp0_mdata !== 14'h0) begin
      n_bad++; $display("FAIL wr_rsp0_quiet: got v=%b m=%h want v=0 m=0", wr_rsp0_valid, wr_rsp0_mdata); end
    tick();                                   // N+3
    n_cmp++; if (rd_rsp_valid !== 1'b0 || wr_rsp1_valid !== 1'b0) begin
      n_bad++; $display("FAIL n3_idle: got rd=%b wr1=%b want 0 0", rd_rsp_valid, wr_rsp1_valid); end
    tick();                                   // N+4
    n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_mdata !== 14'h22) begin
      n_bad++; $display("FAIL rd_rsp_n4: got v=%b m=%h want v=1 m=22", rd_rsp_valid, rd_rsp_mdata); end
    n_cmp++; if (rd_rsp_data !== {64{8'hA5}}) begin
      n_bad++; $display("FAIL rd_data_n4: got %h want a5 repeated", rd_rsp_data); end
    tick();                                   // N+5
    n_cmp++; if (rd_rsp_valid !== 1'b0 || rd_rsp_mdata !== 14'h0 || rd_rsp_data !== 512'h0) begin
      n_bad++; $display("FAIL rd_idle_zero: got v=%b m=%h want all zero", rd_rsp_valid, rd_rsp_mdata); end
  endtask

  task automatic test_collision();
    wr_req_en = 1; wr_req_addr = 20'h8; wr_req_mdata = 14'h1; wr_req_data = '0;
    tick();
    wr_req_en = 0;
    repeat (4) tick();
    wr_req_en = 1; wr_req_addr = 20'h8; wr_req_mdata = 14'h2; wr_req_data = {64{8'h3C}};
    rd_req_en = 1; rd_req_addr = 20'h8; rd_req_mdata = 14'h3;
    tick();                                   // N
    wr_req_en = 0; rd_req_en = 0;
    tick(); tick();                           // N+2
    n_cmp++; if (wr_rsp0_valid !== 1'b1 || wr_rsp0_mdata !== 14'h2 || wr_rsp1_valid !== 1'b0) begin
      n_bad++; $display("FAIL coll_wr_ch0: got v0=%b m0=%h v1=%b want 1 2 0", wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid); end
    tick();                                   // N+3
    n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_mdata !== 14'h3 || rd_rsp_data !== {64{8'h3C}}) begin
      n_bad++; $display("FAIL coll_rd_new: got v=%b m=%h d=%h want 1 3 3c repeated", rd_rsp_valid, rd_rsp_mdata, rd_rsp_data); end
    tick();
  endtask

  task automatic test_wrap();
    wr_req_en = 1; wr_req_addr = 20'h00400; wr_req_mdata = 14'h55; wr_req_data = {16{32'hDEADBEEF}};
    tick();                                   // N
    wr_req_en = 0; rd_req_en = 1; rd_req_addr = 20'h00000; rd_req_mdata = 14'h66;
    tick();                                   // N+1
    rd_req_en = 0;
    tick();                                   // N+2
    n_cmp++; if (wr_rsp0_valid !== 1'b1 || wr_rsp0_mdata !== 14'h55) begin
      n_bad++; $display("FAIL wrap_wr_ch0: got v=%b m=%h want 1 55", wr_rsp0_valid, wr_rsp0_mdata); end
    tick(); tick();                           // N+4
    n_cmp++; if (rd_rsp_valid !== 1'b1 || rd_rsp_mdata !== 14'h66 || rd_rsp_data !== {16{32'hDEADBEEF}}) begin
      n_bad++; $display("FAIL wrap_rd: got v=%b m=%h d=%h want 1 66 deadbeef repeated", rd_rsp_valid, rd_rsp_mdata, rd_rsp_data); end
    tick();
  endtask

  task automatic test_stall_almostfull();
    int got, first, last;
    mem_stall = 1;
    for (int i = 0; i < 16; i++) begin
      rd_req_en = 1; rd_req_addr = 20'(i); rd_req_mdata = 14'(12'h100 + i);
      tick();
      if (i == 10) begin
        n_cmp++; if (rd_req_almostfull !== 1'b0) begin
          n_bad++; $display("FAIL af_at_11: got %b want 0", rd_req_almostfull); end
      end
      if (i == 11) begin
        n_cmp++; if (rd_req_almostfull !== 1'b1) begin
          n_bad++; $display("FAIL af_at_12: got %b want 1", rd_req_almostfull); end
      end
    end
    n_cmp++; if (overflow_err !== 1'b0 || rd_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_no_ovf: got ovf=%b rd=%b want 0 0", overflow_err, rd_rsp_valid); end
    rd_req_mdata = 14'h1FF;
    tick();                                   // 17th push, dropped
    rd_req_en = 0;
    n_cmp++; if (overflow_err !== 1'b1) begin
      n_bad++; $display("FAIL ovf_17th: got %b want 1", overflow_err); end
    mem_stall = 0;
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (rd_rsp_valid === 1'b1) begin
        n_cmp++; if (got >= 16 || rd_rsp_mdata !== 14'(12'h100 + got)) begin
          n_bad++; $display("FAIL drain_tag: got %h want %h (index %0d)", rd_rsp_mdata, 14'(12'h100 + got), got); end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    n_cmp++; if (got !== 16) begin
      n_bad++; $display("FAIL drain_count: got %0d want 16", got); end
    n_cmp++; if (last - first !== 15) begin
      n_bad++; $display("FAIL drain_b2b: got span %0d want 15", last - first); end
    n_cmp++; if (first !== 2) begin
      n_bad++; $display("FAIL drain_latency: got cycle %0d want 2", first); end
    n_cmp++; if (rd_req_almostfull !== 1'b0 || overflow_err !== 1'b1) begin
      n_bad++; $display("FAIL drain_flags: got af=%b ovf=%b want 0 1", rd_req_almostfull, overflow_err); end
  endtask

  task automatic test_reset_midstream();
    int got;
    for (int i = 0; i < 8; i++) begin
      rd_req_en = 1; rd_req_addr = 20'(i); rd_req_mdata = 14'(12'h200 + i);
      tick();                                 // last iteration is edge N
    end
    rd_req_en = 0;
    tick();                                   // N+1
    reset_n = 0;
    tick();                                   // N+2 under reset
    n_cmp++; if (rd_req_almostfull !== 1'b0 || overflow_err !== 1'b0 || rd_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL midrst_flags: got af=%b ovf=%b rd=%b want 0 0 0", rd_req_almostfull, overflow_err, rd_rsp_valid); end
    reset_n = 1;
    rd_req_en = 1; rd_req_addr = 20'h5; rd_req_mdata = 14'h3AB;
    tick();
    rd_req_en = 0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd_rsp_valid === 1'b1) begin
        n_cmp++; if (rd_rsp_mdata !== 14'h3AB) begin
          n_bad++; $display("FAIL midrst_stale: got tag %h want 3ab", rd_rsp_mdata); end
        got++;
      end
    end
    n_cmp++; if (got !== 1) begin
      n_bad++; $display("FAIL midrst_count: got %0d want 1", got); end
    n_cmp++; if (rd_req_almostfull !== 1'b0 || wr_req_almostfull !== 1'b0) begin
      n_bad++; $display("FAIL midrst_af: got %b %b want 0 0", rd_req_almostfull, wr_req_almostfull); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_wrap();
    test_stall_almostfull();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
